timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shared interval-timer controller that arbitrates one internal WIDTH-bit up-counter between two requesters. A granted requester gets the counter for a programmable length, observes the running count, and receives a one-cycle done pulse when its interval expires. Round-robin arbitration guarantees fairness. The block sits between requesting control logic and the counter datapath, and is fully synchronous replacement sequencing for the ripple-style counters.

## Interface
Parameters:
- WIDTH, 4, counter and length width in bits

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 level request
- req1  input  1  requester 1 level request
- len0  input  WIDTH  requester 0 terminal count, sampled at grant
- len1  input  WIDTH  requester 1 terminal count, sampled at grant
- gnt0  output  1  requester 0 owns counter
- gnt1  output  1  requester 1 owns counter
- busy  output  1  state is RUN or DONE
- count  output  WIDTH  current counter value
- done0  output  1  one-cycle expiry pulse, requester 0
- done1  output  1  one-cycle expiry pulse, requester 1
- abort  input  1  cancel current interval (only with TIMER_ARB_ABORT_EN)
- aborted  output  1  one-cycle cancel pulse (only with TIMER_ARB_ABORT_EN)

## Operation
- States: IDLE, RUN, DONE. All outputs registered.
- Reset: state IDLE, RR pointer = 0 (req0 preferred), all outputs 0, count 0, latched length 0.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the pointer side. On grant: latch that len, count <= 0, gntX <= 1, go RUN.
- RUN: count increments by 1 per cycle. When count == latched len: gntX <= 0, doneX <= 1, go DONE. count holds len during DONE.
- DONE: exactly one cycle. doneX returns to 0, count <= 0, pointer <= other requester, go IDLE.
- req and len changes during RUN/DONE are ignored. The grant is held until expiry regardless of req.
- len = 0: RUN lasts one cycle with count 0, then DONE.
- Max len = 2^WIDTH-1. Count stops at len and never wraps.
- gnt0 and gnt1 are never both 1. done0 and done1 are never both 1.
- A requester still asserting req after its done is re-arbitrated in IDLE. If the other side requests, the other side wins.

## Timing
- req seen in IDLE at edge n -> gnt and busy high after edge n, count 0.
- count = k after edge n+k, for k = 0..len.
- gnt low, done high after edge n+len+1. Back in IDLE after edge n+len+2.
- Minimum grant-to-grant spacing: len+3 cycles.
- Reset mid-interval: next cycle all outputs 0, state IDLE, no done pulse issued.

## Configuration
- TIMER_ARB_ABORT_EN defined:
  - abort and aborted ports exist.
  - abort = 1 in RUN: next cycle gnt 0, count 0, aborted = 1 for one cycle, no done pulse, pointer moves to the other side, state IDLE.
  - abort in IDLE or DONE is ignored.
  - If abort arrives on the same cycle as count == len, abort wins.
- TIMER_ARB_ABORT_EN undefined: no abort or aborted ports. Every granted interval runs to completion.

## Test plan
- Reset, then req0 = 1 with len0 = 3 -> gnt0 after 1 cycle; count 0, 1, 2, 3; done0 pulse 1 cycle; IDLE 6 cycles after req.
- req0 and req1 both held, len0 = 2, len1 = 1 -> grants alternate 0, 1, 0, 1; gnt0 and gnt1 never overlap; each done pulse is 1 cycle.
- len1 = 0 with req1 only -> gnt1 for 1 cycle with count 0, then done1.
- len0 = 15 (WIDTH 4) -> count reaches 15, no wrap to 0 before done0.
- rst pulsed with count = 2 mid-interval -> next cycle all outputs 0, no done pulse; a later req0 is granted first.
- With TIMER_ARB_ABORT_EN: abort at count 1 of len 5 -> aborted pulse, no done; a pending req of the other side is granted next.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit interval counter between two requesters.
// Optional abort support is compiled in when TIMER_ARB_ABORT_EN is defined.
module timer_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done0,
  output logic             done1
`ifdef TIMER_ARB_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state;
  logic             r_ptr, w_ptr;
  logic             r_owner, w_owner;
  logic [WIDTH-1:0] r_len, w_len;
  logic [WIDTH-1:0] r_count, w_count;
  logic             r_gnt0, w_gnt0;
  logic             r_gnt1, w_gnt1;
  logic             r_busy, w_busy;
  logic             r_done0, w_done0;
  logic             r_done1, w_done1;
  logic             w_abort;
  logic             w_pick1;

`ifdef TIMER_ARB_ABORT_EN
  logic r_aborted;

  assign w_abort = abort;
  assign aborted = r_aborted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= (r_state == S_RUN) && abort;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // Contention goes to the pointer side; a lone request always wins.
  assign w_pick1 = req1 && (!req0 || r_ptr);

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_len   = r_len;
    w_count = r_count;
    w_gnt0  = r_gnt0;
    w_gnt1  = r_gnt1;
    w_busy  = r_busy;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_owner = w_pick1;
          w_len   = w_pick1 ? len1 : len0;
          w_count = '0;
          w_gnt0  = !w_pick1;
          w_gnt1  = w_pick1;
          w_busy  = 1'b1;
          w_state = S_RUN;
        end
      end
      S_RUN: begin
        // Abort takes priority over a coincident terminal count.
        if (w_abort) begin
          w_gnt0  = 1'b0;
          w_gnt1  = 1'b0;
          w_busy  = 1'b0;
          w_count = '0;
          w_ptr   = !r_owner;
          w_state = S_IDLE;
        end else if (r_count == r_len) begin
          w_gnt0  = 1'b0;
          w_gnt1  = 1'b0;
          w_done0 = !r_owner;
          w_done1 = r_owner;
          w_state = S_DONE;
        end else begin
          w_count = r_count + ONE;
        end
      end
      S_DONE: begin
        w_count = '0;
        w_busy  = 1'b0;
        w_ptr   = !r_owner;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_len   <= '0;
      r_count <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_len   <= w_len;
      r_count <= w_count;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_busy  <= w_busy;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign busy  = r_busy;
  assign count = r_count;
  assign done0 = r_done0;
  assign done1 = r_done1;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed scenarios then random traffic,
// compared each cycle against an interval-timeline reference model.
module tb_timer_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] len0, len1;
  logic             gnt0, gnt1, busy, done0, done1;
  logic [WIDTH-1:0] count;
  logic             ab;
  logic             ab_out;

  timer_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .len0  (len0),
    .len1  (len1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .busy  (busy),
    .count (count),
    .done0 (done0),
    .done1 (done1)
`ifdef TIMER_ARB_ABORT_EN
    ,
    .abort   (ab),
    .aborted (ab_out)
`endif
  );

`ifndef TIMER_ARB_ABORT_EN
  assign ab_out = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: an interval is described by its grant edge, owner and length.
  int t = 0;
  bit m_active = 0;
  int m_tg = 0, m_L = 0, m_owner = 0, m_ptr = 0;
  int e_gnt0, e_gnt1, e_busy, e_count, e_done0, e_done1, e_ab;
  int last_owner = -1;
  int max_count0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    int d;
    e_done0 = 0; e_done1 = 0; e_ab = 0;
    if (rst) begin
      m_active = 0; m_ptr = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_count = 0;
      return;
    end
    if (m_active) begin
      d = t - m_tg;
      if (ab && d <= m_L + 1) begin
        e_ab = 1; m_active = 0; m_ptr = 1 - m_owner;
        e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_count = 0;
      end else if (d <= m_L) begin
        e_count = d;
      end else if (d == m_L + 1) begin
        e_gnt0 = 0; e_gnt1 = 0; e_count = m_L;
        e_done0 = (m_owner == 0); e_done1 = (m_owner == 1);
      end else begin
        m_active = 0; m_ptr = 1 - m_owner;
        e_busy = 0; e_count = 0;
      end
    end else if (req0 || req1) begin
      m_owner  = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
      m_L      = (m_owner == 1) ? int'(len1) : int'(len0);
      m_tg     = t;
      m_active = 1;
      e_gnt0 = (m_owner == 0); e_gnt1 = (m_owner == 1);
      e_busy = 1; e_count = 0;
    end
  endtask

  task automatic step();
    logic pg0, pg1;
    pg0 = gnt0; pg1 = gnt1;
    model_edge();
    @(posedge clk);
    #1;
    chk("gnt0", gnt0, e_gnt0);
    chk("gnt1", gnt1, e_gnt1);
    chk("busy", busy, e_busy);
    chk("count", count, e_count);
    chk("done0", done0, e_done0);
    chk("done1", done1, e_done1);
    chk("aborted", ab_out, e_ab);
    chk("gnt_excl", gnt0 & gnt1, 0);
    chk("done_excl", done0 & done1, 0);
    if (gnt0 && count > max_count0) max_count0 = count;
    t++;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0; ab = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("reset_gnt", gnt0 | gnt1 | busy, 0);

    // Single request, len 3.
    req0 = 1'b1; len0 = 4'd3;
    step();
    chk("first_grant", gnt0, 1);
    req0 = 1'b0; len0 = 4'd9;
    repeat (7) step();

    // Both held: grants must alternate.
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd1;
    last_owner = -1;
    for (int i = 0; i < 30; i++) begin
      logic pg0, pg1;
      pg0 = gnt0; pg1 = gnt1;
      step();
      if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
        if (last_owner >= 0) chk("alternate", gnt1, (last_owner == 0) ? 1 : 0);
        last_owner = gnt1 ? 1 : 0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) step();

    // len 0 on requester 1.
    req1 = 1'b1; len1 = 4'd0;
    step();
    req1 = 1'b0;
    repeat (4) step();

    // Full-scale length, no wrap.
    max_count0 = 0;
    req0 = 1'b1; len0 = 4'd15;
    step();
    req0 = 1'b0;
    repeat (20) step();
    chk("max_count", max_count0, 15);

    // Reset mid-interval, then contention: requester 0 must win.
    req1 = 1'b1; len1 = 4'd5;
    step();
    req1 = 1'b0;
    begin
      int n = 0;
      while (!(count == 4'd2 && gnt1) && n < 20) begin step(); n++; end
      chk("reach_count2", (n < 20) ? 1 : 0, 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd1; len1 = 4'd1;
    step();
    chk("post_rst_gnt0", gnt0, 1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) step();

`ifdef TIMER_ARB_ABORT_EN
    // Abort at count 1 of len 5; pending requester 1 is granted next.
    req0 = 1'b1; len0 = 4'd5;
    step();
    req0 = 1'b0; req1 = 1'b1; len1 = 4'd2;
    step();
    ab = 1'b1;
    step();
    ab = 1'b0;
    chk("abort_pulse", ab_out, 1);
    step();
    chk("abort_next_gnt1", gnt1, 1);
    req1 = 1'b0;
    repeat (6) step();
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      len0 = WIDTH'($urandom_range(0, 6));
      len1 = WIDTH'($urandom_range(0, 6));
      rst  = ($urandom_range(0, 59) == 0);
`ifdef TIMER_ARB_ABORT_EN
      ab   = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
    rst = 1'b0; ab = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
